// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo interleaver write side.
// Supported PB lengths are listed here so every user agrees on them.
package turbo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam logic [11:0] PB_LEN_16  = 12'h040;
  localparam logic [11:0] PB_LEN_136 = 12'h220;
  localparam logic [11:0] PB_LEN_520 = 12'h820;

  function automatic logic pb_len_valid(
    input logic [11:0] len
  );
    return (len == PB_LEN_16)
        || (len == PB_LEN_136)
        || (len == PB_LEN_520);
  endfunction

endpackage

// File: rtl/turbo_tx_wr.sv
// Interleaver write side: stores one PB of coded symbols in RAM,
// then hands pb_len/pb_offset to the reader and waits for rd_done.
module turbo_tx_wr
  import turbo_pkg::*;
#(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [D_WIDTH-1:0] din,
  input  logic               din_vld,
  output logic               din_rdy,
  input  logic               sof,
  input  logic [A_WIDTH-1:0] pb_len,
  input  logic [A_WIDTH-1:0] pb_offset,
  input  logic               rd_done,
  output logic               wen,
  output logic [A_WIDTH-1:0] waddr,
  output logic [D_WIDTH-1:0] wdata,
  output logic               rd_start,
  output logic [A_WIDTH-1:0] pb_len_o,
  output logic [A_WIDTH-1:0] pb_offset_o,
  output logic               busy,
  output logic               err_len,
  output logic               err_sof,
  output logic               err_ovf
);

  state_t             state;
  logic [A_WIDTH-1:0] cnt;
  logic [A_WIDTH-1:0] len_l;
  logic [A_WIDTH-1:0] off_l;
  logic               acc;
  logic               last;

  assign din_rdy = ((state == IDLE) || (state == FILL)) && !n_rst;
  assign acc     = din_vld && din_rdy;
  assign last    = (cnt == len_l - A_WIDTH'(1));
  assign busy    = (state != IDLE);

  assign pb_len_o    = len_l;
  assign pb_offset_o = off_l;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_l    <= '0;
      off_l    <= '0;
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      rd_start <= 1'b0;
      err_len  <= 1'b0;
      err_sof  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      wen      <= 1'b0;
      rd_start <= (state == COMMIT);
      err_len  <= 1'b0;
      err_sof  <= 1'b0;
      err_ovf  <= din_vld && !din_rdy;
      unique case (state)
        IDLE, FILL: begin
          if (acc && sof) begin
            // A sof mid-PB aborts and restarts as if from IDLE.
            err_sof <= (state == FILL);
            if (pb_len_valid(pb_len)) begin
              len_l <= pb_len;
              off_l <= pb_offset;
              cnt   <= A_WIDTH'(1);
              wen   <= 1'b1;
              waddr <= pb_offset;
              wdata <= din;
              state <= FILL;
            end else begin
              err_len <= 1'b1;
              cnt     <= '0;
              state   <= IDLE;
            end
          end else if (acc && (state == IDLE)) begin
            err_sof <= 1'b1;
          end else if (acc) begin
            wen   <= 1'b1;
            waddr <= off_l + cnt;
            wdata <= din;
            cnt   <= cnt + A_WIDTH'(1);
            if (last) begin
              cnt   <= '0;
              state <= COMMIT;
            end
          end
        end
        COMMIT: state <= WAIT;
        WAIT: begin
          if (rd_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_tx_wr.sv
// Bench for turbo_tx_wr: vector table, directed PB sequences and
// randomized PBs checked against an address/data scoreboard.
module tb_turbo_tx_wr;
  import turbo_pkg::*;

  localparam int DW = 2;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic          sof = 1'b0;
  logic [AW-1:0] pb_len = '0;
  logic [AW-1:0] pb_offset = '0;
  logic          rd_done = 1'b0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rd_start;
  logic [AW-1:0] pb_len_o;
  logic [AW-1:0] pb_offset_o;
  logic          busy;
  logic          err_len;
  logic          err_sof;
  logic          err_ovf;

  turbo_tx_wr #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .n_rst(n_rst), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .sof(sof), .pb_len(pb_len),
    .pb_offset(pb_offset), .rd_done(rd_done), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rd_start(rd_start),
    .pb_len_o(pb_len_o), .pb_offset_o(pb_offset_o), .busy(busy),
    .err_len(err_len), .err_sof(err_sof), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int bad = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every RAM write and every rd_start, in order.
  logic [AW+DW-1:0] got_w[$];
  logic [AW+DW-1:0] exp_w[$];
  int     wp = 0;
  int     n_rs = 0;
  longint lw_cyc = 0;
  always @(negedge clk) begin
    if (wen) begin
      got_w.push_back({waddr, wdata});
      lw_cyc = cyc;
    end
    if (rd_start) n_rs++;
  end

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_writes(string nm);
    int n;
    int idx;
    n = got_w.size() - wp;
    check({nm, " write count"}, 64'(n), 64'(exp_w.size()));
    idx = -1;
    for (int i = 0; i < exp_w.size() && i < n; i++)
      if (idx < 0 && got_w[wp+i] !== exp_w[i]) idx = i;
    if (idx >= 0)
      check({nm, " addr/data"}, 64'(got_w[wp+idx]), 64'(exp_w[idx]));
    else
      check({nm, " addr/data"}, 64'(0), 64'(0 * n));
    wp = got_w.size();
    exp_w.delete();
  endtask

  // Send n symbols of a PB; sof on the first; expected writes at off+i.
  task automatic feed(logic [AW-1:0] len, logic [AW-1:0] off,
                      int n, bit gap, logic exp_esof);
    for (int i = 0; i < n; i++) begin
      if (gap)
        while ($urandom_range(3) == 0) begin
          din_vld = 1'b0;
          sof = 1'b0;
          step();
        end
      din_vld = 1'b1;
      sof = (i == 0);
      pb_len = len;
      pb_offset = off;
      din = DW'($urandom);
      exp_w.push_back({AW'(int'(off) + i), din});
      step();
      if (i == 0) check("err_sof at sof", 64'(err_sof), 64'(exp_esof));
    end
    din_vld = 1'b0;
    sof = 1'b0;
  endtask

  // Wait for rd_start and check the hand-off; mode 1 resets in WAIT.
  task automatic finish_pb(string nm, logic [AW-1:0] len,
                           logic [AW-1:0] off, int mode);
    int base;
    int k;
    base = n_rs;
    k = 0;
    while (!rd_start && k < 20) begin
      step();
      k++;
    end
    check({nm, " rd_start seen"}, 64'(rd_start), 64'(1));
    check({nm, " rd_start after last wen"}, 64'(cyc), 64'(lw_cyc + 1));
    check({nm, " pb_len_o"}, 64'(pb_len_o), 64'(len));
    check({nm, " pb_offset_o"}, 64'(pb_offset_o), 64'(off));
    repeat (3) step();
    check({nm, " single rd_start"}, 64'(n_rs - base), 64'(1));
    check({nm, " rdy low in WAIT"}, 64'(din_rdy), 64'(0));
    check({nm, " busy in WAIT"}, 64'(busy), 64'(1));
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    check({nm, " err_ovf"}, 64'(err_ovf), 64'(1));
    step();
    check({nm, " err_ovf one cycle"}, 64'(err_ovf), 64'(0));
    compare_writes(nm);
    if (mode == 0) begin
      step();
      check({nm, " rd_done ignored?"}, 64'(din_rdy), 64'(0));
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      check({nm, " rdy after rd_done"}, 64'(din_rdy), 64'(1));
      check({nm, " idle after rd_done"}, 64'(busy), 64'(0));
    end else begin
      n_rst = 1'b1;
      step();
      check({nm, " outs in reset"},
            64'({wen, waddr, wdata, rd_start, pb_len_o, pb_offset_o,
                 busy, err_len, err_sof, err_ovf, din_rdy}), 64'(0));
      n_rst = 1'b0;
      #1;
      check({nm, " rdy after reset"}, 64'(din_rdy), 64'(1));
      step();
    end
  endtask

  typedef struct {
    logic          sof;
    logic          vld;
    logic [DW-1:0] din;
    logic [AW-1:0] len;
    logic [AW-1:0] off;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_el;
    logic          e_es;
    logic          e_busy;
  } vec_t;

  vec_t tv[9];

  initial begin
    int base;
    logic [AW-1:0] l;
    logic [AW-1:0] o;

    tv[0] = '{1'b0, 1'b1, 2'd1, 12'h040, 12'h000, 1'b0, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 2'd2, 12'h100, 12'h000, 1'b0, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 2'd0, 12'h040, 12'h000, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b1, 1'b1, 2'd3, 12'h040, 12'h123, 1'b1, 12'h123, 2'd3, 1'b0, 1'b0, 1'b1};
    tv[4] = '{1'b0, 1'b1, 2'd1, 12'h040, 12'h123, 1'b1, 12'h124, 2'd1, 1'b0, 1'b0, 1'b1};
    tv[5] = '{1'b1, 1'b1, 2'd2, 12'h220, 12'hFFF, 1'b1, 12'hFFF, 2'd2, 1'b0, 1'b1, 1'b1};
    tv[6] = '{1'b0, 1'b1, 2'd0, 12'h220, 12'hFFF, 1'b1, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1};
    tv[7] = '{1'b1, 1'b1, 2'd1, 12'h100, 12'h000, 1'b0, 12'h000, 2'd0, 1'b1, 1'b1, 1'b0};
    tv[8] = '{1'b0, 1'b0, 2'd0, 12'h040, 12'h000, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0};

    // Reset state
    step();
    step();
    check("reset outs",
          64'({wen, waddr, wdata, rd_start, pb_len_o, pb_offset_o,
               busy, err_len, err_sof, err_ovf, din_rdy}), 64'(0));
    n_rst = 1'b0;
    #1;
    check("rdy after reset", 64'(din_rdy), 64'(1));

    // Single-cycle protocol vectors
    foreach (tv[i]) begin
      sof = tv[i].sof;
      din_vld = tv[i].vld;
      din = tv[i].din;
      pb_len = tv[i].len;
      pb_offset = tv[i].off;
      step();
      check($sformatf("vec%0d wen", i), 64'(wen), 64'(tv[i].e_wen));
      if (tv[i].e_wen) begin
        check($sformatf("vec%0d waddr", i), 64'(waddr), 64'(tv[i].e_addr));
        check($sformatf("vec%0d wdata", i), 64'(wdata), 64'(tv[i].e_data));
      end
      check($sformatf("vec%0d err_len", i), 64'(err_len), 64'(tv[i].e_el));
      check($sformatf("vec%0d err_sof", i), 64'(err_sof), 64'(tv[i].e_es));
      check($sformatf("vec%0d busy", i), 64'(busy), 64'(tv[i].e_busy));
      check($sformatf("vec%0d din_rdy", i), 64'(din_rdy), 64'(1));
    end
    step();
    wp = got_w.size();

    // PB16 back-to-back at offset 0
    feed(PB_LEN_16, 12'h000, 64, 1'b0, 1'b0);
    finish_pb("pb16", PB_LEN_16, 12'h000, 0);

    // PB136 gapped at offset 0x010
    feed(PB_LEN_136, 12'h010, 544, 1'b1, 1'b0);
    finish_pb("pb136", PB_LEN_136, 12'h010, 0);

    // PB520 wrapping past the top of RAM
    feed(PB_LEN_520, 12'h7F0, 2080, 1'b0, 1'b0);
    finish_pb("pb520 wrap", PB_LEN_520, 12'h7F0, 0);

    // Unsupported length, then a good sof on the next cycle
    sof = 1'b1;
    din_vld = 1'b1;
    pb_len = 12'h100;
    step();
    check("bad len err_len", 64'(err_len), 64'(1));
    check("bad len wen", 64'(wen), 64'(0));
    check("bad len busy", 64'(busy), 64'(0));
    feed(PB_LEN_16, 12'h040, 64, 1'b0, 1'b0);
    finish_pb("after bad len", PB_LEN_16, 12'h040, 0);

    // Restart after 20 symbols
    feed(PB_LEN_16, 12'h000, 20, 1'b0, 1'b0);
    feed(PB_LEN_16, 12'h100, 64, 1'b0, 1'b1);
    finish_pb("restart", PB_LEN_16, 12'h100, 0);

    // Reset in FILL at cnt 30
    base = n_rs;
    feed(PB_LEN_16, 12'h300, 30, 1'b0, 1'b0);
    n_rst = 1'b1;
    step();
    check("fill reset outs",
          64'({wen, waddr, wdata, rd_start, pb_len_o, pb_offset_o,
               busy, err_len, err_sof, err_ovf, din_rdy}), 64'(0));
    n_rst = 1'b0;
    #1;
    check("fill reset rdy", 64'(din_rdy), 64'(1));
    repeat (70) step();
    check("fill reset no rd_start", 64'(n_rs - base), 64'(0));
    compare_writes("fill reset");

    // Reset in WAIT
    feed(PB_LEN_16, 12'h555, 64, 1'b1, 1'b0);
    finish_pb("wait reset", PB_LEN_16, 12'h555, 1);

    // Randomized PBs
    for (int p = 0; p < 4; p++) begin
      case ($urandom_range(5))
        0:       l = PB_LEN_520;
        1, 2:    l = PB_LEN_136;
        default: l = PB_LEN_16;
      endcase
      o = AW'($urandom);
      feed(l, o, int'(l), 1'b1, 1'b0);
      finish_pb($sformatf("rand%0d", p), l, o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/turbo_tx_wr.md
Name: turbo_tx_wr

Overview:
HPGP interleaver write side: accepts a serial stream of D_WIDTH-bit coded symbols for one PHY block (PB) and writes them sequentially into the interleaver RAM. After the last symbol is written it pulses rd_start together with the latched pb_len/pb_offset, and then holds off input until the read side reports rd_done. It drives the RAM write port (wen/waddr/wdata) and the start/pb_len/pb_offset inputs of the interleaver reader.

Parameters:
D_WIDTH, 2, symbol width (bits per RAM word)
A_WIDTH, 12, RAM address width; also the width of pb_len, pb_offset and the symbol counter

Ports:
clk  input  1  clock
n_rst  input  1  reset; synchronous, active-high (the name is kept for codebase consistency; a value of 1 resets)
din  input  D_WIDTH  symbol in
din_vld  input  1  symbol valid
din_rdy  output  1  block accepts a symbol this cycle
sof  input  1  first symbol of a PB; qualified by din_vld
pb_len  input  A_WIDTH  PB length in symbols; sampled with sof
pb_offset  input  A_WIDTH  RAM base address; sampled with sof
rd_done  input  1  read side finished the PB
wen  output  1  RAM write enable
waddr  output  A_WIDTH  RAM write address
wdata  output  D_WIDTH  RAM write data
rd_start  output  1  one-cycle pulse: PB stored, reader may start
pb_len_o  output  A_WIDTH  latched pb_len, stable from rd_start until the next accepted sof
pb_offset_o  output  A_WIDTH  latched pb_offset, same stability as pb_len_o
busy  output  1  state != IDLE
err_len  output  1  one-cycle pulse: sof with unsupported pb_len
err_sof  output  1  one-cycle pulse: sof protocol violation
err_ovf  output  1  one-cycle pulse: din_vld while din_rdy=0

Behaviour:
- Reset (n_rst=1 at a clk edge): state=IDLE, cnt=0; every output is 0, including din_rdy.
- Accept condition: din_vld & din_rdy. din_rdy = (state==IDLE or FILL) and not in reset.
- Supported pb_len values: 12'h040, 12'h220, 12'h820 (PB16, PB136, PB520).
- States:
  - IDLE
    - Accepted sof with a supported pb_len: latch pb_len and pb_offset, write this symbol at cnt 0, set cnt=1, go to FILL.
    - sof with an unsupported pb_len: pulse err_len, drop the symbol, stay in IDLE.
    - Accepted symbol without sof: pulse err_sof, drop it, stay in IDLE.
  - FILL
    - Accepted symbol without sof: write it at cnt, then cnt++.
    - Accepted sof: pulse err_sof, abort the current PB and restart exactly as from IDLE (re-latch pb_len/pb_offset; the unsupported-length rule applies and returns to IDLE).
    - When the symbol at cnt==pb_len_l-1 is accepted: go to COMMIT.
  - COMMIT: lasts one cycle; din_rdy=0; go to WAIT.
  - WAIT: din_rdy=0; go to IDLE on the first cycle in which rd_done=1.
- rd_done is ignored in IDLE, FILL and COMMIT.
- Write port: registered, one-cycle latency. A symbol accepted in cycle t gives wen=1 in t+1, with waddr=(pb_offset_l+cnt) mod 2^A_WIDTH and wdata=din. Address wrap-around is intended.
- rd_start: registered from COMMIT. If the last symbol is accepted in cycle t, its wen is in t+1 and rd_start is high only in t+2. pb_len_o and pb_offset_o are valid in that cycle.
- err_ovf: pulses on din_vld in COMMIT or WAIT; the symbol is dropped and no wen is generated.
- Error pulses are registered: high in the cycle after the offending input.
- Back-to-back symbols (din_vld held high) are accepted at one per clock; gaps in din_vld are allowed.
- Reset mid-operation: the PB is abandoned with no rd_start. RAM contents are not cleared.

Decomposition:
- Shared package turbo_pkg:
  - state encodings IDLE/FILL/COMMIT/WAIT (2 bits)
  - constants PB_LEN_16=12'h040, PB_LEN_136=12'h220, PB_LEN_520=12'h820
  - function pb_len_valid()
- No sub-module; the RAM is instantiated externally as the existing ram block, with this module driving its write port.

Test Plan:
1. sof + pb_len=0x040, pb_offset=0, 64 back-to-back symbols -> 64 wen with waddr 0x000..0x03F and data matching; rd_start high exactly one cycle, one cycle after the wen for 0x03F; din_rdy=0 until a rd_done pulse, then 1.
2. pb_len=0x220, pb_offset=0x010, din_vld randomly gapped -> 544 wen at waddr 0x010..0x22F in order; pb_len_o=0x220 and pb_offset_o=0x010 at rd_start.
3. pb_len=0x820, pb_offset=0x7F0 -> 2080 writes; waddr runs 0x7F0..0xFFF, wraps to 0x000, ends at 0x00F; single rd_start.
4. sof with pb_len=0x100 -> err_len pulse one cycle later; no wen; busy stays 0; a valid sof on the next cycle is accepted normally.
5. pb_len=0x040: 20 symbols, then another sof with pb_offset=0x100 -> err_sof pulse; subsequent writes start at waddr 0x100; rd_start follows 64 symbols of the new PB only.
6. din_vld in WAIT -> err_ovf pulse, no wen. Reset asserted in WAIT, or in FILL at cnt 30 -> next cycle all outputs 0 and state IDLE; din_rdy=1 once reset is released; no rd_start.
